bist_misr_compactor: RTL

//  Multiple-input signature register (MISR) stage directly downstream of the capture register (Basic_Register q).

---
 rtl/bist_misr_compactor_if.sv | 30 +++
 rtl/bist_misr_compactor.sv | 123 ++++++++++++
 2 files changed

// File: rtl/bist_misr_compactor_if.sv
// Purpose: response-stream / control / status bundle of the MISR compactor.
//  master : BIST controller side (drives start/abort/num_vectors/golden and the response stream)
//  slave  : compactor side (drives in_ready/busy/done/pass/signature/vec_count)
interface bist_misr_compactor_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  start;
  logic                  abort;
  logic [CNT_WIDTH-1:0]  num_vectors;
  logic [DATA_WIDTH-1:0] golden;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [DATA_WIDTH-1:0] signature;
  logic [CNT_WIDTH-1:0]  vec_count;

  modport master (
    output start, abort, num_vectors, golden, in_valid, in_data,
    input  in_ready, busy, done, pass, signature, vec_count
  );

  modport slave (
    input  start, abort, num_vectors, golden, in_valid, in_data,
    output in_ready, busy, done, pass, signature, vec_count
  );
endinterface

// File: rtl/bist_misr_compactor.sv
// Purpose: MISR compaction of a programmed number of captured response words into
//  one signature, compared against a golden value at the end of the run.
// Ports:
//  clk    : rising-edge clock
//  rst_n  : asynchronous active-low reset
//  bus    : bist_misr_compactor_if.slave (start/abort/num_vectors/golden in,
//           in_valid/in_data response stream in, in_ready/busy/done/pass/
//           signature/vec_count out; all outputs registered)
module bist_misr_compactor #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  POLY       = DATA_WIDTH'(32'h04C11DB7),
  parameter logic [DATA_WIDTH-1:0]  SEED       = '0,
  parameter int unsigned            CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bist_misr_compactor_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPACT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_accept;
  logic                  w_launch;
  logic [DATA_WIDTH-1:0] w_sig_next;

  logic [DATA_WIDTH-1:0] r_sig;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  r_num;
  logic                  r_pass;
  logic                  r_done;
  logic                  r_busy;
  logic                  r_in_ready;

  // Galois MISR step: shift left, fold the MSB back through the taps, mix in the word
  assign w_sig_next = {r_sig[DATA_WIDTH-2:0], 1'b0}
                    ^ (r_sig[DATA_WIDTH-1] ? POLY : '0)
                    ^ bus.in_data;

  // Next-state logic; abort outranks both start and accept
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_launch = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.abort && bus.start) begin
          w_launch = 1'b1;
          w_next   = (bus.num_vectors != '0) ? S_COMPACT : S_DONE;
        end
      end
      S_COMPACT: begin
        if (bus.abort) begin
          w_next = S_IDLE;
        end else if (bus.in_valid) begin
          w_accept = 1'b1;
          if (r_cnt == r_num - CNT_WIDTH'(1)) begin
            w_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register plus state-mirroring status flags (registered from next state)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_done     <= (w_next == S_DONE);
      r_busy     <= (w_next != S_IDLE);
      r_in_ready <= (w_next == S_COMPACT);
    end
  end

  // Datapath: signature, word counter, latched run length, pass flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig  <= SEED;
      r_cnt  <= '0;
      r_num  <= '0;
      r_pass <= 1'b0;
    end else begin
      if (w_launch) begin
        r_sig  <= SEED;
        r_cnt  <= '0;
        r_num  <= bus.num_vectors;
        r_pass <= 1'b0;
      end else if (w_accept) begin
        r_sig <= w_sig_next;
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
      if (r_state == S_DONE) begin
        r_pass <= !bus.abort && (r_sig == bus.golden);
      end else if (r_state == S_COMPACT && bus.abort) begin
        r_pass <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.signature = r_sig;
  assign bus.vec_count = r_cnt;

endmodule
